// File: rtl/noc_ext_adapter.sv
// Core-to-router network adapter: a TX FIFO feeding a flit serialiser toward the router,
// and an RX reassembler that checks destination and source before delivering whole words.
module noc_ext_adapter #(
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 8,
    parameter int ADDR_W    = 4,
    parameter int DEPTH     = 4,
    localparam int FLIT_W   = 1 + 2*ADDR_W + PAYLOAD_W,
    localparam int LVL_W    = $clog2(DEPTH+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] r_name,
    input  logic              core_valid,
    input  logic [DATA_W-1:0] core_data,
    input  logic [ADDR_W-1:0] core_dest,
    output logic              core_ready,
    output logic [FLIT_W-1:0] to_r,
    input  logic              to_r_ready,
    input  logic [FLIT_W-1:0] f_r,
    output logic [DATA_W-1:0] to_c,
    output logic              to_c_valid,
    output logic [ADDR_W-1:0] to_c_src,
    output logic              rx_err,
    output logic [LVL_W-1:0]  tx_level
);
    localparam int BEATS = DATA_W / PAYLOAD_W;
    localparam int BW    = $clog2(BEATS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ADDR_W + DATA_W;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;
    logic [0:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [ADDR_W-1:0] tx_dest;
    logic [BW-1:0]     beat;
    logic              push;
    logic              pop;
    logic              xfer;
    logic              last_beat;
    logic              fifo_empty;

    // Readiness looks only at the current fill level, so a pop never makes room for a same-cycle push.
    assign core_ready = !rst && (count != LVL_W'(DEPTH));
    assign push       = core_valid && core_ready;
    assign fifo_empty = (count == '0);
    assign xfer       = (state == SEND) && to_r_ready;
    assign last_beat  = (beat == BW'(BEATS-1));
    assign pop        = !fifo_empty && ((state == IDLE) || (xfer && last_beat));
    assign to_r       = (state == SEND) ? {1'b1, tx_dest, r_name, shreg[DATA_W-1 -: PAYLOAD_W]} : '0;
    assign tx_level   = count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {core_dest, core_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + LVL_W'(1);
            else if (pop && !push) count <= count - LVL_W'(1);
        end
    end

    // Loading the next word on the last accepted beat keeps packets back to back with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            tx_dest <= '0;
            beat    <= '0;
        end else if (pop) begin
            state             <= SEND;
            {tx_dest, shreg}  <= mem[rd_ptr];
            beat              <= '0;
        end else if (xfer) begin
            if (last_beat) begin
                state <= IDLE;
            end else begin
                shreg <= shreg << PAYLOAD_W;
                beat  <= beat + BW'(1);
            end
        end
    end

    logic              rx_valid;
    logic [ADDR_W-1:0] rx_dest;
    logic [ADDR_W-1:0] rx_src;
    logic [PAYLOAD_W-1:0] rx_payload;
    logic [BW-1:0]     asm_cnt;
    logic [ADDR_W-1:0] asm_src;
    logic [DATA_W-1:0] asm_word;
    logic [DATA_W-1:0] assembled;
    logic              restart;

    assign rx_valid   = f_r[FLIT_W-1];
    assign rx_dest    = f_r[FLIT_W-2 -: ADDR_W];
    assign rx_src     = f_r[PAYLOAD_W+ADDR_W-1 -: ADDR_W];
    assign rx_payload = f_r[PAYLOAD_W-1:0];
    assign assembled  = {asm_word[DATA_W-PAYLOAD_W-1:0], rx_payload};
    assign restart    = (asm_cnt == '0) || (rx_src != asm_src);

    // A source change mid-word abandons the partial word and treats the new flit as a fresh beat 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_c       <= '0;
            to_c_valid <= 1'b0;
            to_c_src   <= '0;
            rx_err     <= 1'b0;
            asm_cnt    <= '0;
            asm_src    <= '0;
            asm_word   <= '0;
        end else begin
            to_c       <= '0;
            to_c_valid <= 1'b0;
            rx_err     <= 1'b0;
            if (rx_valid) begin
                if (rx_dest != r_name) begin
                    rx_err <= 1'b1;
                end else if (restart) begin
                    rx_err   <= (asm_cnt != '0);
                    asm_src  <= rx_src;
                    asm_word <= DATA_W'(rx_payload);
                    asm_cnt  <= BW'(1);
                end else if (asm_cnt == BW'(BEATS-1)) begin
                    to_c       <= assembled;
                    to_c_valid <= 1'b1;
                    to_c_src   <= asm_src;
                    asm_cnt    <= '0;
                end else begin
                    asm_word <= assembled;
                    asm_cnt  <= asm_cnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_ext_adapter.sv
// Randomised and directed bench for noc_ext_adapter, checked every cycle against a
// queue-based model of the TX packets and RX reassembly, plus literal pins on known sequences.
module tb_noc_ext_adapter;
    localparam int DATA_W    = 32;
    localparam int PAYLOAD_W = 8;
    localparam int ADDR_W    = 4;
    localparam int DEPTH     = 4;
    localparam int FLIT_W    = 1 + 2*ADDR_W + PAYLOAD_W;
    localparam int LVL_W     = $clog2(DEPTH+1);
    localparam int BEATS     = DATA_W / PAYLOAD_W;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] r_name;
    logic              core_valid;
    logic [DATA_W-1:0] core_data;
    logic [ADDR_W-1:0] core_dest;
    logic              core_ready;
    logic [FLIT_W-1:0] to_r;
    logic              to_r_ready;
    logic [FLIT_W-1:0] f_r;
    logic [DATA_W-1:0] to_c;
    logic              to_c_valid;
    logic [ADDR_W-1:0] to_c_src;
    logic              rx_err;
    logic [LVL_W-1:0]  tx_level;

    int n_checks = 0;
    int n_fail   = 0;

    noc_ext_adapter #(
        .DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .r_name(r_name),
        .core_valid(core_valid), .core_data(core_data), .core_dest(core_dest),
        .core_ready(core_ready), .to_r(to_r), .to_r_ready(to_r_ready), .f_r(f_r),
        .to_c(to_c), .to_c_valid(to_c_valid), .to_c_src(to_c_src),
        .rx_err(rx_err), .tx_level(tx_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: words waiting, flits of the packet in flight, partial RX payloads.
    logic [ADDR_W+DATA_W-1:0] m_fifo [$];
    logic [FLIT_W-1:0]        m_cur  [$];
    logic [PAYLOAD_W-1:0]     m_part [$];
    logic [ADDR_W-1:0]        m_psrc = '0;
    logic [FLIT_W-1:0]        exp_to_r = '0;
    int                       exp_level = 0;
    logic                     exp_cvalid = 1'b0;
    logic [DATA_W-1:0]        exp_c = '0;
    logic [ADDR_W-1:0]        exp_csrc = '0;
    logic                     exp_err = 1'b0;
    logic                     m_push;
    logic [ADDR_W+DATA_W-1:0] m_word;
    logic [DATA_W-1:0]        m_shift;
    logic [DATA_W-1:0]        m_acc;
    logic [ADDR_W-1:0]        fd;
    logic [ADDR_W-1:0]        fs;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fifo.delete();
            m_cur.delete();
            m_part.delete();
            exp_to_r   = '0;
            exp_level  = 0;
            exp_cvalid = 1'b0;
            exp_c      = '0;
            exp_csrc   = '0;
            exp_err    = 1'b0;
        end else begin
            m_push = core_valid && (m_fifo.size() < DEPTH);
            if (m_cur.size() > 0 && to_r_ready) void'(m_cur.pop_front());
            if (m_cur.size() == 0 && m_fifo.size() > 0) begin
                m_word = m_fifo.pop_front();
                for (int b = 0; b < BEATS; b++) begin
                    m_shift = m_word[DATA_W-1:0] >> (DATA_W - PAYLOAD_W*(b+1));
                    m_cur.push_back({1'b1, m_word[ADDR_W+DATA_W-1:DATA_W], r_name, m_shift[PAYLOAD_W-1:0]});
                end
            end
            if (m_push) m_fifo.push_back({core_dest, core_data});
            exp_to_r  = (m_cur.size() > 0) ? m_cur[0] : '0;
            exp_level = m_fifo.size();

            exp_cvalid = 1'b0;
            exp_c      = '0;
            exp_err    = 1'b0;
            if (f_r[FLIT_W-1]) begin
                fd = f_r[FLIT_W-2 -: ADDR_W];
                fs = f_r[PAYLOAD_W+ADDR_W-1 -: ADDR_W];
                if (fd != r_name) begin
                    exp_err = 1'b1;
                end else begin
                    if (m_part.size() > 0 && fs != m_psrc) begin
                        exp_err = 1'b1;
                        m_part.delete();
                    end
                    if (m_part.size() == 0) m_psrc = fs;
                    m_part.push_back(f_r[PAYLOAD_W-1:0]);
                    if (m_part.size() == BEATS) begin
                        m_acc = '0;
                        foreach (m_part[i]) m_acc = (m_acc << PAYLOAD_W) | DATA_W'(m_part[i]);
                        exp_c      = m_acc;
                        exp_csrc   = m_psrc;
                        exp_cvalid = 1'b1;
                        m_part.delete();
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("core_ready", 64'(core_ready), 64'(!rst && (m_fifo.size() < DEPTH)));
        checkOutput("to_r", 64'(to_r), 64'(exp_to_r));
        checkOutput("tx_level", 64'(tx_level), 64'(exp_level));
        checkOutput("to_c_valid", 64'(to_c_valid), 64'(exp_cvalid));
        checkOutput("to_c", 64'(to_c), 64'(exp_c));
        checkOutput("rx_err", 64'(rx_err), 64'(exp_err));
        if (exp_cvalid) checkOutput("to_c_src", 64'(to_c_src), 64'(exp_csrc));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] dest, input logic [DATA_W-1:0] data);
        core_valid = 1'b1;
        core_dest  = dest;
        core_data  = data;
        tick();
        core_valid = 1'b0;
    endtask

    task automatic sendFlit(input logic [ADDR_W-1:0] d, input logic [ADDR_W-1:0] s, input logic [PAYLOAD_W-1:0] p);
        f_r = {1'b1, d, s, p};
        tick();
    endtask

    logic [31:0] rnd;
    logic [FLIT_W-1:0] pin_flits [4];

    initial begin
        rst = 1'b1;
        r_name = 4'd3;
        core_valid = 1'b0;
        core_data = '0;
        core_dest = '0;
        to_r_ready = 1'b1;
        f_r = '0;
        repeat (3) tick();
        checkOutput("reset_to_r", 64'(to_r), 64'h0);
        checkOutput("reset_level", 64'(tx_level), 64'h0);
        rst = 1'b0;
        tick();

        $display("[TB] single word");
        pin_flits[0] = 17'h153A1;
        pin_flits[1] = 17'h153B2;
        pin_flits[2] = 17'h153C3;
        pin_flits[3] = 17'h153D4;
        applyStimulus(4'd5, 32'hA1B2C3D4);
        @(negedge clk);
        checkOutput("pin_idle_before", 64'(to_r), 64'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("pin_flit", 64'(to_r), 64'(pin_flits[i]));
        end
        @(negedge clk);
        checkOutput("pin_idle_after", 64'(to_r), 64'h0);

        $display("[TB] backpressure and full");
        tick();
        to_r_ready = 1'b0;
        core_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rnd = $urandom;
            core_data = rnd;
            core_dest = ADDR_W'(i);
            tick();
        end
        core_valid = 1'b0;
        #1;
        checkOutput("pin_full_level", 64'(tx_level), 64'd4);
        checkOutput("pin_full_ready", 64'(core_ready), 64'd0);
        to_r_ready = 1'b1;
        repeat (24) tick();

        $display("[TB] mid-packet stall");
        applyStimulus(4'd6, 32'hCAFEF00D);
        repeat (3) tick();
        to_r_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("pin_stall_hold", 64'(to_r), 64'h163F0);
            tick();
        end
        to_r_ready = 1'b1;
        repeat (6) tick();

        $display("[TB] rx assembly");
        sendFlit(4'd3, 4'd7, 8'h12);
        sendFlit(4'd3, 4'd7, 8'h34);
        sendFlit(4'd3, 4'd7, 8'h56);
        sendFlit(4'd3, 4'd7, 8'h78);
        f_r = '0;
        @(negedge clk);
        checkOutput("pin_rx_word", 64'(to_c), 64'h12345678);
        checkOutput("pin_rx_src", 64'(to_c_src), 64'd7);
        checkOutput("pin_rx_valid", 64'(to_c_valid), 64'd1);
        checkOutput("pin_rx_noerr", 64'(rx_err), 64'd0);
        @(negedge clk);
        checkOutput("pin_rx_pulse_end", 64'(to_c_valid), 64'd0);

        $display("[TB] rx errors");
        tick();
        sendFlit(4'd9, 4'd7, 8'hEE);
        f_r = '0;
        @(negedge clk);
        checkOutput("pin_bad_dest_err", 64'(rx_err), 64'd1);
        tick();
        sendFlit(4'd3, 4'd7, 8'h01);
        sendFlit(4'd3, 4'd7, 8'h02);
        sendFlit(4'd3, 4'd4, 8'hA0);
        f_r = '0;
        @(negedge clk);
        checkOutput("pin_src_change_err", 64'(rx_err), 64'd1);
        tick();
        sendFlit(4'd3, 4'd4, 8'hA1);
        sendFlit(4'd3, 4'd4, 8'hA2);
        sendFlit(4'd3, 4'd4, 8'hA3);
        f_r = '0;
        @(negedge clk);
        checkOutput("pin_restart_word", 64'(to_c), 64'hA0A1A2A3);
        checkOutput("pin_restart_src", 64'(to_c_src), 64'd4);

        $display("[TB] reset mid-transfer");
        tick();
        applyStimulus(4'd2, 32'h01020304);
        applyStimulus(4'd2, 32'h05060708);
        tick();
        rst = 1'b1;
        #1;
        checkOutput("pin_rst_to_r", 64'(to_r), 64'h0);
        checkOutput("pin_rst_level", 64'(tx_level), 64'h0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        checkOutput("pin_rst_quiet", 64'(to_r), 64'h0);
        applyStimulus(4'd4, 32'h55667788);
        repeat (6) tick();

        $display("[TB] random traffic");
        for (int n = 0; n < 800; n++) begin
            rnd = $urandom;
            core_valid = rnd[0];
            core_dest  = rnd[7:4];
            to_r_ready = (rnd[11:8] < 4'd11);
            core_data  = $urandom;
            rnd = $urandom;
            if (rnd[3:0] < 4'd10)
                f_r = {1'b1, (rnd[6:4] == 3'd0) ? rnd[11:8] : r_name,
                       (rnd[15:13] == 3'd0) ? 4'd2 : 4'd7, rnd[23:16]};
            else
                f_r = '0;
            tick();
        end
        core_valid = 1'b0;
        f_r = '0;
        to_r_ready = 1'b1;
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
